// File: rtl/muldiv_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq_if
//  Description : Request/response bundle between the control unit and the
//                iterative multiply/divide unit (operands in, HI/LO out).
//  Revision    : 1.0  initial release
// ============================================================================
interface muldiv_seq_if #(
   parameter int WIDTH = 32
) ();
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   // Requester side: issues operations, consumes results
   modport master (
      output start, op, a, b,
      input  busy, done, div_zero, hi, lo
   );

   // Execution-unit side
   modport slave (
      input  start, op, a, b,
      output busy, done, div_zero, hi, lo
   );
endinterface
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq
//  Description : Iterative multiply/divide unit producing HI/LO for
//                MULT/MULTU/DIV/DIVU. One result bit per clock: shift-add on
//                operand magnitudes for multiply, restoring division for
//                divide, followed by a single sign-correction cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_seq #(
   parameter int WIDTH     = 32,
   parameter bit SIGNED_EN = 1'b1
) (
   input  wire logic    clk,
   input  wire logic    reset,
   muldiv_seq_if.slave  bus
);

   localparam int             CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_accept;
   logic               w_fin;

   logic [CW-1:0]      r_cnt;
   logic               r_is_div;
   logic               r_divz;
   logic               r_neg_lo;     // sign of product / quotient
   logic               r_neg_hi;     // sign of remainder (dividend sign)
   logic [WIDTH-1:0]   r_opnd;       // multiplicand magnitude or divisor magnitude
   logic [2*WIDTH-1:0] r_acc;        // {upper, lower} working accumulator

   logic               r_done;
   logic               r_div_zero;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   // Operand decode at the accepting edge
   logic               w_is_div_in;
   logic               w_signed_in;
   logic               w_a_neg;
   logic               w_b_neg;
   logic               w_divz_in;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;

   assign w_is_div_in = bus.op[1];
   assign w_signed_in = SIGNED_EN && !bus.op[0];
   assign w_a_neg     = w_signed_in & bus.a[WIDTH-1];
   assign w_b_neg     = w_signed_in & bus.b[WIDTH-1];
   assign w_a_mag     = w_a_neg ? -bus.a : bus.a;
   assign w_b_mag     = w_b_neg ? -bus.b : bus.b;
   assign w_divz_in   = w_is_div_in && (bus.b == '0);

   // Multiply step: conditionally add multiplicand to the upper half, shift right
   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_mul_step;

   assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
   assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

   // Divide step: shift partial remainder left by one, trial-subtract divisor
   logic [WIDTH:0]     w_div_trial;
   logic               w_div_ge;
   logic [WIDTH-1:0]   w_div_rem;
   logic [2*WIDTH-1:0] w_div_step;

   assign w_div_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_opnd};
   assign w_div_ge    = ~w_div_trial[WIDTH];
   // When the trial fails the shifted remainder is below the divisor, so its top bit is 0
   assign w_div_rem   = w_div_ge ? w_div_trial[WIDTH-1:0]
                                 : {r_acc[2*WIDTH-2:WIDTH], r_acc[WIDTH-1]};
   assign w_div_step  = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};

   // Sign-corrected results presented on the finishing edge
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_quot_fix;
   logic [WIDTH-1:0]   w_rem_fix;

   assign w_prod_fix = r_neg_lo ? -r_acc : r_acc;
   assign w_quot_fix = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem_fix  = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state and control strobes; divide-by-zero skips the iterations
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_fin       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_accept    = 1'b1;
               w_state_nxt = w_divz_in ? S_FIN : S_RUN;
            end
         end
         S_RUN: begin
            if (r_cnt == C_LAST) w_state_nxt = S_FIN;
         end
         S_FIN: begin
            w_fin       = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Operand capture and one-bit-per-cycle iteration
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_divz   <= 1'b0;
         r_neg_lo <= 1'b0;
         r_neg_hi <= 1'b0;
         r_opnd   <= '0;
         r_acc    <= '0;
      end else if (w_accept) begin
         r_cnt    <= '0;
         r_is_div <= w_is_div_in;
         r_divz   <= w_divz_in;
         r_neg_lo <= w_a_neg ^ w_b_neg;
         r_neg_hi <= w_a_neg;
         if (w_is_div_in) begin
            r_opnd <= w_b_mag;
            r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
         end else begin
            r_opnd <= w_a_mag;
            r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
         end
      end else if (r_state == S_RUN) begin
         r_cnt <= r_cnt + 1'b1;
         r_acc <= r_is_div ? w_div_step : w_mul_step;
      end
   end

   // Result registers and completion pulses; HI/LO hold except on a real finish
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hi       <= '0;
         r_lo       <= '0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         r_done     <= w_fin;
         r_div_zero <= w_fin & r_divz;
         if (w_fin && !r_divz) begin
            if (r_is_div) begin
               r_hi <= w_rem_fix;
               r_lo <= w_quot_fix;
            end else begin
               r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
               r_lo <= w_prod_fix[WIDTH-1:0];
            end
         end
      end
   end

   assign bus.busy     = (r_state != S_IDLE);
   assign bus.done     = r_done;
   assign bus.div_zero = r_div_zero;
   assign bus.hi       = r_hi;
   assign bus.lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_seq
//  Description : Self-checking bench for muldiv_seq: directed corner cases and
//                random operations against an arithmetic reference model,
//                on a 32-bit signed unit and 8-bit signed/unsigned units.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_seq;

   logic clk;
   logic reset;

   int n_cmp = 0;
   int n_err = 0;

   muldiv_seq_if #(.WIDTH(32)) if32 ();
   muldiv_seq_if #(.WIDTH(8))  if8s ();
   muldiv_seq_if #(.WIDTH(8))  if8u ();

   muldiv_seq #(.WIDTH(32), .SIGNED_EN(1'b1)) u_dut32 (.clk(clk), .reset(reset), .bus(if32));
   muldiv_seq #(.WIDTH(8),  .SIGNED_EN(1'b1)) u_dut8s (.clk(clk), .reset(reset), .bus(if8s));
   muldiv_seq #(.WIDTH(8),  .SIGNED_EN(1'b0)) u_dut8u (.clk(clk), .reset(reset), .bus(if8u));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        dz;
      logic [63:0] hi;
      logic [63:0] lo;
   } res_t;

   // Architectural results of the previous completed operation per unit
   logic [63:0] m32_hi, m32_lo, m8s_hi, m8s_lo, m8u_hi, m8u_lo;
   res_t        e32;
   int          lat32;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on sign-interpreted operands
   function automatic res_t ref_op(input int w, input bit sen, input logic [1:0] op,
                                   input logic [63:0] a, input logic [63:0] b,
                                   input logic [63:0] hi0, input logic [63:0] lo0);
      res_t        r;
      logic [63:0] mask;
      logic [63:0] p;
      longint      sa, sb, q, rm;
      bit          sgn;
      mask = (64'd1 << w) - 64'd1;
      sgn  = sen && (op[0] == 1'b0);
      sa   = (sgn && a[w-1]) ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb   = (sgn && b[w-1]) ? longint'(b) - (longint'(1) << w) : longint'(b);
      r.dz = 1'b0;
      r.hi = hi0;
      r.lo = lo0;
      if (!op[1]) begin
         p    = sa * sb;
         r.lo = p & mask;
         r.hi = (p >> w) & mask;
      end else if (b == 64'd0) begin
         r.dz = 1'b1;
      end else begin
         q    = sa / sb;
         rm   = sa % sb;
         r.lo = 64'(q) & mask;
         r.hi = 64'(rm) & mask;
      end
      return r;
   endfunction

   function automatic logic [31:0] pick32();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         5:       return 32'($urandom_range(0, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   // Drive one request into the 32-bit unit; returns just after the accepting edge
   task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      e32   = ref_op(32, 1'b1, op, {32'd0, a}, {32'd0, b}, m32_hi, m32_lo);
      lat32 = e32.dz ? 1 : 33;
      if32.start = 1'b1; if32.op = op; if32.a = a; if32.b = b;
      @(posedge clk); #1;
      if32.start = 1'b0; if32.op = 2'($urandom); if32.a = $urandom; if32.b = $urandom;
      chk("busy_accept", {63'd0, if32.busy}, 64'd1);
   endtask

   // Wait for completion, optionally pulsing start while busy; leaves us in the done cycle
   task automatic finish32(input bit noise);
      int n  = 0;
      int bz = 0;
      while (n < lat32 + 4) begin
         @(posedge clk); n++; #1;
         if (if32.done) break;
         if (!if32.busy) bz++;
         if32.start = noise ? 1'($urandom) : 1'b0;
         if32.op = 2'($urandom); if32.a = $urandom; if32.b = $urandom;
      end
      if32.start = 1'b0;
      chk("latency32",  64'(n), 64'(lat32));
      chk("busy_run32", 64'(bz), 64'd0);
      chk("busy_done32", {63'd0, if32.busy}, 64'd0);
      chk("hi32", {32'd0, if32.hi}, e32.hi);
      chk("lo32", {32'd0, if32.lo}, e32.lo);
      chk("dz32", {63'd0, if32.div_zero}, {63'd0, e32.dz});
      m32_hi = e32.hi;
      m32_lo = e32.lo;
   endtask

   task automatic go32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit noise);
      issue32(op, a, b);
      finish32(noise);
   endtask

   task automatic no_done_next();
      @(posedge clk); #1;
      chk("done_single", {63'd0, if32.done}, 64'd0);
   endtask

   // Same request to both 8-bit units; each checked against its own signedness model
   task automatic go8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      res_t es, eu;
      int   ns = 0, nu = 0;
      logic [7:0] hs = 0, ls = 0, hu = 0, lu = 0;
      logic ds = 0, du = 0;
      es = ref_op(8, 1'b1, op, {56'd0, a}, {56'd0, b}, m8s_hi, m8s_lo);
      eu = ref_op(8, 1'b0, op, {56'd0, a}, {56'd0, b}, m8u_hi, m8u_lo);
      if8s.start = 1'b1; if8s.op = op; if8s.a = a; if8s.b = b;
      if8u.start = 1'b1; if8u.op = op; if8u.a = a; if8u.b = b;
      @(posedge clk); #1;
      if8s.start = 1'b0; if8u.start = 1'b0;
      for (int i = 1; i <= 14; i++) begin
         @(posedge clk); #1;
         if (if8s.done && ns == 0) begin ns = i; hs = if8s.hi; ls = if8s.lo; ds = if8s.div_zero; end
         if (if8u.done && nu == 0) begin nu = i; hu = if8u.hi; lu = if8u.lo; du = if8u.div_zero; end
      end
      chk("latency8s", 64'(ns), es.dz ? 64'd1 : 64'd9);
      chk("hi8s", {56'd0, hs}, es.hi);
      chk("lo8s", {56'd0, ls}, es.lo);
      chk("dz8s", {63'd0, ds}, {63'd0, es.dz});
      chk("latency8u", 64'(nu), eu.dz ? 64'd1 : 64'd9);
      chk("hi8u", {56'd0, hu}, eu.hi);
      chk("lo8u", {56'd0, lu}, eu.lo);
      chk("dz8u", {63'd0, du}, {63'd0, eu.dz});
      m8s_hi = es.hi; m8s_lo = es.lo;
      m8u_hi = eu.hi; m8u_lo = eu.lo;
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_hi"},   {32'd0, if32.hi}, 64'd0);
      chk({tag, "_lo"},   {32'd0, if32.lo}, 64'd0);
      chk({tag, "_busy"}, {63'd0, if32.busy}, 64'd0);
      chk({tag, "_done"}, {63'd0, if32.done}, 64'd0);
      chk({tag, "_dz"},   {63'd0, if32.div_zero}, 64'd0);
   endtask

   initial begin
      int dones;
      reset = 1'b1;
      if32.start = 0; if32.op = 0; if32.a = 0; if32.b = 0;
      if8s.start = 0; if8s.op = 0; if8s.a = 0; if8s.b = 0;
      if8u.start = 0; if8u.op = 0; if8u.a = 0; if8u.b = 0;
      m32_hi = 0; m32_lo = 0; m8s_hi = 0; m8s_lo = 0; m8u_hi = 0; m8u_lo = 0;
      repeat (2) @(posedge clk);
      #1;
      check_cleared("reset");
      reset = 1'b0;
      @(posedge clk); #1;

      // Signed multiply with a negative operand
      go32(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
      chk("t1_hi", {32'd0, if32.hi}, 64'hFFFF_FFFF);
      chk("t1_lo", {32'd0, if32.lo}, 64'hFFFF_FFEB);
      no_done_next();

      // Largest unsigned product, then back-to-back divide issued in the done cycle
      go32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      chk("t2_hi", {32'd0, if32.hi}, 64'hFFFF_FFFE);
      go32(2'b11, 32'd7, 32'd2, 1'b0);
      chk("t2_lo", {32'd0, if32.lo}, 64'd3);

      // Divide by zero keeps the preceding HI/LO (1/3)
      go32(2'b10, 32'd5, 32'd0, 1'b0);
      chk("t4_hi", {32'd0, if32.hi}, 64'd1);
      chk("t4_lo", {32'd0, if32.lo}, 64'd3);

      // Signed divide sign rules
      go32(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
      chk("t3_hi", {32'd0, if32.hi}, 64'hFFFF_FFFF);
      go32(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);
      chk("t3_lo", {32'd0, if32.lo}, 64'hFFFF_FFFD);
      go32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      go32(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);

      // Start pulses while busy must not queue a second operation
      go32(2'b00, 32'd1234, 32'hFFFF_0001, 1'b1);
      no_done_next();

      // Random traffic with occasional back-to-back issue and busy-time start noise
      for (int i = 0; i < 40; i++) begin
         logic [31:0] b;
         b = ($urandom_range(0, 5) == 0) ? 32'd0 : pick32();
         go32(2'($urandom), pick32(), b, 1'($urandom));
         if ($urandom_range(0, 1) == 0) begin
            @(posedge clk); #1;
         end
      end

      // 8-bit units: MIN / -1 under both signedness settings, then random
      go8(2'b10, 8'h80, 8'hFF);
      chk("t5_lo8s", m8s_lo, 64'h80);
      chk("t5_hi8u", m8u_hi, 64'h80);
      for (int i = 0; i < 60; i++) begin
         logic [7:0] b8;
         b8 = ($urandom_range(0, 6) == 0) ? 8'd0 : 8'($urandom);
         go8(2'($urandom), 8'($urandom), b8);
      end

      // Abort a multiply mid-run with an asynchronous reset
      issue32(2'b00, 32'h1234_5678, 32'h9ABC_DEF1);
      repeat (9) @(posedge clk);
      #3 reset = 1'b1;
      #1 check_cleared("abort");
      @(posedge clk); #1;
      reset = 1'b0;
      m32_hi = 0; m32_lo = 0; m8s_hi = 0; m8s_lo = 0; m8u_hi = 0; m8u_lo = 0;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (if32.done) dones++;
      end
      chk("abort_nodone", 64'(dones), 64'd0);
      go32(2'b00, 32'd6, 32'd7, 1'b0);
      chk("t6_lo", {32'd0, if32.lo}, 64'd42);
      chk("t6_hi", {32'd0, if32.hi}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
